fifo_write_arbiter: RTL

//  Shares the single write port of the 4-bit async FIFO between two producers (req0, req1).

---
 rtl/fifo_ctrl_pkg.sv | 27 ++
 rtl/sat_counter.sv | 20 ++
 rtl/fifo_write_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared encodings and helpers for the async FIFO write-side control.
// Imported by the write arbiter and its beat counters.
package fifo_ctrl_pkg;

  localparam int FIFO_DATA_WIDTH = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    GRANT0 = ST_GRANT0,
    GRANT1 = ST_GRANT1
  } arb_state_t;

  // Bits needed to hold the values 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Used for the per-producer beat statistics.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded sharing of the FIFO write port
// between two producers, with per-producer beat counters.
module fifo_write_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int MAX_BURST  = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  input  logic                  fifo_full,
  output logic                  fifo_winc,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  grant_id,
  output logic                  busy,
  output logic [CNT_W-1:0]      beats0,
  output logic [CNT_W-1:0]      beats1
);

  localparam int BW = clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  arb_state_t    state, state_nxt;
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          last_id, last_nxt;
  logic          own_id, own_valid, other_valid, beat;

  always_comb begin
    own_id      = (state == GRANT1);
    busy        = (state != IDLE);
    own_valid   = own_id ? req1_valid : req0_valid;
    other_valid = own_id ? req0_valid : req1_valid;
    beat        = busy & own_valid & ~fifo_full;
    req0_ready  = beat & ~own_id;
    req1_ready  = beat & own_id;
    fifo_winc   = beat;
    fifo_wdata  = '0;
    if (beat) fifo_wdata = own_id ? req1_data : req0_data;
    grant_id    = own_id;
  end

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    last_nxt  = last_id;
    unique case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          state_nxt = last_id ? GRANT0 : GRANT1;
        end else if (req0_valid) begin
          state_nxt = GRANT0;
        end else if (req1_valid) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (beat) burst_nxt = burst_cnt + 1'b1;
        // A full stall keeps both grant and burst position.
        if ((beat && (burst_cnt == LAST_BEAT)) || !own_valid) begin
          last_nxt  = own_id;
          burst_nxt = '0;
          if (other_valid) begin
            state_nxt = own_id ? GRANT0 : GRANT1;
          end else if (!own_valid) begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      last_id   <= 1'b1;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      last_id   <= last_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_beats0 (
    .clk (clk),
    .rst (rst),
    .inc (req0_ready),
    .q   (beats0)
  );

  sat_counter #(.CNT_W(CNT_W)) u_beats1 (
    .clk (clk),
    .rst (rst),
    .inc (req1_ready),
    .q   (beats1)
  );

endmodule
